// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: shares the single L2 line port between L1I fills and L1D fills/write-backs.
// Latency: a request seen in IDLE drives the L2 command from the next cycle; the response is routed combinationally.
// Backpressure: the owner holds its request until resp, and one REST cycle follows every response; `L2_ARB_ROUND_ROBIN_EN selects the round-robin tie-break (default: fixed D priority).
module l2_port_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_read,
   input  logic [ADDR_WIDTH-1:0] i_address,
   output logic [LINE_WIDTH-1:0] i_rdata,
   output logic                  i_resp,
   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [ADDR_WIDTH-1:0] d_address,
   input  logic [LINE_WIDTH-1:0] d_wdata,
   output logic [LINE_WIDTH-1:0] d_rdata,
   output logic                  d_resp,
   output logic                  l2_read,
   output logic                  l2_write,
   output logic [ADDR_WIDTH-1:0] l2_address,
   output logic [LINE_WIDTH-1:0] l2_wdata,
   input  logic [LINE_WIDTH-1:0] l2_rdata,
   input  logic                  l2_resp,
   output logic                  l2_read_or_write
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2,
      REST    = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   cmd_addr_q, cmd_addr_d;
   logic [LINE_WIDTH-1:0]   cmd_wdata_q, cmd_wdata_d;
   logic                    cmd_write_q, cmd_write_d;
   logic                    req_i, req_d;
   logic                    grant_i, grant_d;
`ifdef L2_ARB_ROUND_ROBIN_EN
   // Set when D was the most recent grant; reset value means "I granted last".
   logic                    last_d_q, last_d_d;
`endif

   // Next-state, grant selection and command capture.
   always_comb begin
      req_i       = i_read;
      req_d       = d_read | d_write;
      state_d     = state_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_wdata_d = cmd_wdata_q;
      cmd_write_d = cmd_write_q;
      grant_i     = 1'b0;
      grant_d     = 1'b0;
`ifdef L2_ARB_ROUND_ROBIN_EN
      last_d_d    = last_d_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_i && req_d) begin
`ifdef L2_ARB_ROUND_ROBIN_EN
               grant_i = last_d_q;
               grant_d = ~last_d_q;
`else
               grant_d = 1'b1;
`endif
            end else begin
               grant_d = req_d;
               grant_i = req_i;
            end
            if (grant_d) begin
               state_d     = SERVE_D;
               cmd_addr_d  = d_address;
               cmd_wdata_d = d_wdata;
               // A simultaneous read+write is treated as a write-back.
               cmd_write_d = d_write;
`ifdef L2_ARB_ROUND_ROBIN_EN
               last_d_d    = 1'b1;
`endif
            end else if (grant_i) begin
               state_d     = SERVE_I;
               cmd_addr_d  = i_address;
               cmd_wdata_d = '0;
               cmd_write_d = 1'b0;
`ifdef L2_ARB_ROUND_ROBIN_EN
               last_d_d    = 1'b0;
`endif
            end
         end
         SERVE_I, SERVE_D: begin
            if (l2_resp) state_d = REST;
         end
         REST:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and latched command registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cmd_addr_q  <= '0;
         cmd_wdata_q <= '0;
         cmd_write_q <= 1'b0;
`ifdef L2_ARB_ROUND_ROBIN_EN
         last_d_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_wdata_q <= cmd_wdata_d;
         cmd_write_q <= cmd_write_d;
`ifdef L2_ARB_ROUND_ROBIN_EN
         last_d_q    <= last_d_d;
`endif
      end
   end

   // L2 command is driven only while a requester owns the port; responses go to the owner.
   always_comb begin
      l2_read    = 1'b0;
      l2_write   = 1'b0;
      l2_address = '0;
      l2_wdata   = '0;
      if (state_q == SERVE_I || state_q == SERVE_D) begin
         l2_read    = ~cmd_write_q;
         l2_write   = cmd_write_q;
         l2_address = cmd_addr_q;
         l2_wdata   = cmd_wdata_q;
      end
      i_resp           = l2_resp & (state_q == SERVE_I);
      d_resp           = l2_resp & (state_q == SERVE_D);
      i_rdata          = l2_rdata;
      d_rdata          = l2_rdata;
      l2_read_or_write = l2_read | l2_write;
   end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb_l2_port_arbiter: scoreboard bench for l2_port_arbiter.
// Expected L2 commands and per-port responses are queued as stimulus is driven and popped by a monitor.
// Inputs change on the falling edge; outputs are sampled 1 ns after it.
module tb_l2_port_arbiter;
   localparam int AW = 32;
   localparam int LW = 256;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          i_read = 1'b0;
   logic [AW-1:0] i_address = '0;
   logic [LW-1:0] i_rdata;
   logic          i_resp;
   logic          d_read = 1'b0;
   logic          d_write = 1'b0;
   logic [AW-1:0] d_address = '0;
   logic [LW-1:0] d_wdata = '0;
   logic [LW-1:0] d_rdata;
   logic          d_resp;
   logic          l2_read;
   logic          l2_write;
   logic [AW-1:0] l2_address;
   logic [LW-1:0] l2_wdata;
   logic [LW-1:0] l2_rdata = '0;
   logic          l2_resp = 1'b0;
   logic          l2_read_or_write;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [LW-1:0] wdata;
   } cmd_t;

   cmd_t          exp_cmd[$];
   logic [LW-1:0] exp_i[$];
   logic [LW-1:0] exp_d[$];

   l2_port_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
      .clk(clk), .reset(reset),
      .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
      .l2_rdata(l2_rdata), .l2_resp(l2_resp), .l2_read_or_write(l2_read_or_write)
   );

   always #5 clk = ~clk;

   function automatic cmd_t mk_cmd(input logic wr, input logic [AW-1:0] addr, input logic [LW-1:0] wdata);
      cmd_t c;
      c.wr = wr; c.addr = addr; c.wdata = wdata;
      return c;
   endfunction

   // Monitor: each new L2 command and each port response is checked against the queues.
   logic mon_prev = 1'b0;
   cmd_t mon_e;
   logic [LW-1:0] mon_r;
   always @(negedge clk) begin
      #1;
      if ((l2_read | l2_write) && !mon_prev) begin
         n_total++;
         if (exp_cmd.size() == 0) begin
            $display("FAIL l2_cmd_unexpected got addr=%h wr=%0b", l2_address, l2_write);
         end else begin
            mon_e = exp_cmd.pop_front();
            if (l2_write !== mon_e.wr || l2_read !== !mon_e.wr || l2_address !== mon_e.addr || l2_wdata !== mon_e.wdata)
               $display("FAIL l2_cmd got wr=%0b rd=%0b addr=%h wdata=%h want wr=%0b addr=%h wdata=%h",
                        l2_write, l2_read, l2_address, l2_wdata, mon_e.wr, mon_e.addr, mon_e.wdata);
            else n_pass++;
         end
      end
      mon_prev = l2_read | l2_write;
      if (i_resp) begin
         n_total++;
         if (exp_i.size() == 0) $display("FAIL i_resp_unexpected got i_resp=1 want 0");
         else begin
            mon_r = exp_i.pop_front();
            if (i_rdata !== mon_r) $display("FAIL i_rdata got %h want %h", i_rdata, mon_r);
            else n_pass++;
         end
      end
      if (d_resp) begin
         n_total++;
         if (exp_d.size() == 0) $display("FAIL d_resp_unexpected got d_resp=1 want 0");
         else begin
            mon_r = exp_d.pop_front();
            if (d_rdata !== mon_r) $display("FAIL d_rdata got %h want %h", d_rdata, mon_r);
            else n_pass++;
         end
      end
   end

   // L2 model: wait (bounded) for a command, answer lat cycles later, return in the REST cycle.
   task automatic serve_l2(input int lat, input logic [LW-1:0] rd);
      int t;
      t = 0;
      while (!(l2_read | l2_write) && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!(l2_read | l2_write)) begin
         n_total++;
         $display("FAIL serve_l2_timeout got no command in %0d cycles want one", t);
         return;
      end
      repeat (lat - 1) @(negedge clk);
      l2_rdata = rd;
      l2_resp  = 1'b1;
      @(negedge clk);
      l2_resp  = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk); #1;
      n_total++;
      if ({l2_read, l2_write, l2_read_or_write, i_resp, d_resp} !== 5'b0)
         $display("FAIL reset_ctrl got %b want 00000", {l2_read, l2_write, l2_read_or_write, i_resp, d_resp});
      else n_pass++;
      n_total++;
      if (l2_address !== '0 || l2_wdata !== '0) $display("FAIL reset_bus got addr=%h wdata=%h want 0", l2_address, l2_wdata);
      else n_pass++;
      @(negedge clk);
      i_read = 1'b1; d_write = 1'b1;
      @(negedge clk); #1;
      n_total++;
      if (l2_read_or_write !== 1'b0) $display("FAIL reset_holds got %b want 0", l2_read_or_write);
      else n_pass++;
      @(negedge clk);
      i_read = 1'b0; d_write = 1'b0; reset = 1'b0;
      @(negedge clk); #1;
      n_total++;
      if (l2_read_or_write !== 1'b0) $display("FAIL reset_release got %b want 0", l2_read_or_write);
      else n_pass++;
   endtask

   task automatic test_single_i_read();
      logic [LW-1:0] a5;
      a5 = {32{8'hA5}};
      @(negedge clk);
      i_read = 1'b1; i_address = 32'h0000_1000;
      exp_cmd.push_back(mk_cmd(1'b0, 32'h0000_1000, '0));
      exp_i.push_back(a5);
      #1;
      n_total++;
      if (l2_read_or_write !== 1'b0) $display("FAIL i_cycle0 got %b want 0", l2_read_or_write);
      else n_pass++;
      @(negedge clk); #1;
      n_total++;
      if (l2_read !== 1'b1 || l2_write !== 1'b0 || l2_address !== 32'h1000)
         $display("FAIL i_cycle1 got rd=%0b wr=%0b addr=%h want rd=1 wr=0 addr=00001000", l2_read, l2_write, l2_address);
      else n_pass++;
      serve_l2(5, a5);
      i_read = 1'b0;
   endtask

   task automatic test_d_writeback();
      logic [LW-1:0] w;
      w = {16{16'h1234}};
      @(negedge clk);
      d_write = 1'b1; d_address = 32'h8000_0040; d_wdata = w;
      exp_cmd.push_back(mk_cmd(1'b1, 32'h8000_0040, w));
      exp_d.push_back({8{32'hCAFE_F00D}});
      @(negedge clk); #1;
      n_total++;
      if (l2_write !== 1'b1 || l2_read !== 1'b0 || l2_read_or_write !== 1'b1)
         $display("FAIL d_wb_cmd got wr=%0b rd=%0b rw=%0b want 1 0 1", l2_write, l2_read, l2_read_or_write);
      else n_pass++;
      @(negedge clk);
      d_address = 32'hDEAD_BEEF; d_wdata = ~w;
      @(negedge clk); #1;
      n_total++;
      if (l2_address !== 32'h8000_0040 || l2_wdata !== w)
         $display("FAIL d_wb_latched got addr=%h wdata=%h want 80000040 %h", l2_address, l2_wdata, w);
      else n_pass++;
      serve_l2(3, {8{32'hCAFE_F00D}});
      d_write = 1'b0;
   endtask

   task automatic test_tie();
      logic [LW-1:0] dw;
      dw = {8{32'h0BAD_F00D}};
      @(negedge clk);
      i_read = 1'b1; i_address = 32'h0000_3000;
      d_read = 1'b1; d_address = 32'h0000_2000; d_wdata = dw;
      exp_cmd.push_back(mk_cmd(1'b0, 32'h0000_2000, dw));
      exp_cmd.push_back(mk_cmd(1'b0, 32'h0000_3000, '0));
      exp_d.push_back({8{32'h1111_0001}});
      exp_i.push_back({8{32'h1111_0002}});
      #1;
      serve_l2(2, {8{32'h1111_0001}});
      d_read = 1'b0;
      #1;
      n_total++;
      if (l2_read_or_write !== 1'b0) $display("FAIL tie_rest got %b want 0", l2_read_or_write);
      else n_pass++;
      @(negedge clk); #1;
      n_total++;
      if (l2_read_or_write !== 1'b0) $display("FAIL tie_idle got %b want 0", l2_read_or_write);
      else n_pass++;
      @(negedge clk); #1;
      n_total++;
      if (l2_read !== 1'b1 || l2_address !== 32'h3000)
         $display("FAIL tie_i_third_cycle got rd=%0b addr=%h want rd=1 addr=00003000", l2_read, l2_address);
      else n_pass++;
      serve_l2(2, {8{32'h1111_0002}});
      i_read = 1'b0;
      // Solo D grant, then a second tie.
      @(negedge clk);
      d_read = 1'b1; d_address = 32'h0000_2100;
      exp_cmd.push_back(mk_cmd(1'b0, 32'h0000_2100, dw));
      exp_d.push_back({8{32'h1111_0003}});
      serve_l2(2, {8{32'h1111_0003}});
      d_read = 1'b0;
      @(negedge clk);
      i_read = 1'b1; i_address = 32'h0000_3100;
      d_read = 1'b1; d_address = 32'h0000_2200;
`ifdef L2_ARB_ROUND_ROBIN_EN
      exp_cmd.push_back(mk_cmd(1'b0, 32'h0000_3100, '0));
      exp_cmd.push_back(mk_cmd(1'b0, 32'h0000_2200, dw));
      exp_i.push_back({8{32'h1111_0004}});
      exp_d.push_back({8{32'h1111_0005}});
      serve_l2(2, {8{32'h1111_0004}});
      i_read = 1'b0;
      serve_l2(2, {8{32'h1111_0005}});
      d_read = 1'b0;
`else
      exp_cmd.push_back(mk_cmd(1'b0, 32'h0000_2200, dw));
      exp_cmd.push_back(mk_cmd(1'b0, 32'h0000_3100, '0));
      exp_d.push_back({8{32'h1111_0004}});
      exp_i.push_back({8{32'h1111_0005}});
      serve_l2(2, {8{32'h1111_0004}});
      d_read = 1'b0;
      serve_l2(2, {8{32'h1111_0005}});
      i_read = 1'b0;
`endif
   endtask

   task automatic test_back_to_back();
      logic [LW-1:0] r;
      @(negedge clk);
      i_read = 1'b1; i_address = 32'h0000_5000;
      d_wdata = '0;
      exp_cmd.push_back(mk_cmd(1'b0, 32'h0000_5000, '0));
      exp_i.push_back({8{32'h2222_0000}});
      serve_l2(2, {8{32'h2222_0000}});
      i_read = 1'b0;
      @(negedge clk);
      i_read = 1'b1; d_read = 1'b1; d_address = 32'h0000_4000;
`ifdef L2_ARB_ROUND_ROBIN_EN
      for (int k = 0; k < 4; k++) begin
         r = {8{32'h3333_0000 + k}};
         if (k % 2 == 0) begin
            exp_cmd.push_back(mk_cmd(1'b0, 32'h0000_4000, '0));
            exp_d.push_back(r);
         end else begin
            exp_cmd.push_back(mk_cmd(1'b0, 32'h0000_5000, '0));
            exp_i.push_back(r);
         end
      end
      for (int k = 0; k < 4; k++) serve_l2(2, {8{32'h3333_0000 + k}});
      d_read = 1'b0; i_read = 1'b0;
`else
      for (int k = 0; k < 3; k++) begin
         exp_cmd.push_back(mk_cmd(1'b0, 32'h0000_4000, '0));
         exp_d.push_back({8{32'h3333_0000 + k}});
      end
      exp_cmd.push_back(mk_cmd(1'b0, 32'h0000_5000, '0));
      exp_i.push_back({8{32'h3333_0003}});
      for (int k = 0; k < 3; k++) serve_l2(2, {8{32'h3333_0000 + k}});
      d_read = 1'b0;
      serve_l2(2, {8{32'h3333_0003}});
      i_read = 1'b0;
`endif
      r = '0;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      d_read = 1'b1; d_address = 32'h0000_6000; d_wdata = '0;
      exp_cmd.push_back(mk_cmd(1'b0, 32'h0000_6000, '0));
      @(negedge clk); #1;
      n_total++;
      if (l2_read !== 1'b1) $display("FAIL rst_mid_serving got %b want 1", l2_read);
      else n_pass++;
      @(negedge clk);
      reset = 1'b1; l2_resp = 1'b1;
      #1;
      n_total++;
      if ({l2_read, l2_write, d_resp} !== 3'b0 || l2_address !== '0)
         $display("FAIL rst_mid_async got rd/wr/resp=%b addr=%h want 000 0", {l2_read, l2_write, d_resp}, l2_address);
      else n_pass++;
      @(negedge clk);
      l2_resp = 1'b0; d_read = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); #1;
         n_total++;
         if (l2_read_or_write !== 1'b0) $display("FAIL rst_mid_quiet cycle %0d got %b want 0", k, l2_read_or_write);
         else n_pass++;
      end
   endtask

   task automatic test_stray_resp();
      @(negedge clk);
      l2_resp = 1'b1; l2_rdata = {8{32'h5A5A_0F0F}};
      i_read = 1'b1; i_address = 32'h0000_7000;
      exp_cmd.push_back(mk_cmd(1'b0, 32'h0000_7000, '0));
      exp_i.push_back({8{32'h4444_0000}});
      #1;
      n_total++;
      if (i_resp !== 1'b0 || d_resp !== 1'b0) $display("FAIL stray_resp got i=%0b d=%0b want 0 0", i_resp, d_resp);
      else n_pass++;
      @(negedge clk);
      l2_resp = 1'b0;
      #1;
      n_total++;
      if (l2_read !== 1'b1 || l2_address !== 32'h7000)
         $display("FAIL stray_still_idle got rd=%0b addr=%h want rd=1 addr=00007000", l2_read, l2_address);
      else n_pass++;
      serve_l2(3, {8{32'h4444_0000}});
      i_read = 1'b0;
   endtask

   task automatic test_drain();
      repeat (3) @(negedge clk);
      #1;
      n_total++;
      if (exp_cmd.size() != 0) $display("FAIL drain_cmd got %0d pending want 0", exp_cmd.size());
      else n_pass++;
      n_total++;
      if (exp_i.size() != 0 || exp_d.size() != 0)
         $display("FAIL drain_resp got i=%0d d=%0d pending want 0 0", exp_i.size(), exp_d.size());
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_i_read();
      test_d_writeback();
      test_tie();
      test_back_to_back();
      test_reset_mid();
      test_stray_resp();
      test_drain();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got no finish want finish");
      $fatal(1, "timeout");
   end
endmodule
